// File: rtl/cart_loader.sv
// Streams an hps_io cartridge download into SDRAM over a toggle write handshake and
// derives the cartridge size mask, copier-header flag and Game Gear flag for reads.
module cart_loader #(
  parameter int         ADDR_W   = 22,
  parameter logic [4:0] GG_INDEX = 5'd2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_wr,
  input  logic              rom_wr_ack,
  output logic [23:0]       rom_waddr,
  output logic [7:0]        rom_wdata,
  input  logic [ADDR_W-1:0] cart_raddr,
  output logic [ADDR_W-1:0] rom_raddr,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              hdr,
  output logic              gg,
  output logic              loaded
);

  typedef enum logic [1:0] {IDLE, STREAM, BUSY, FINISH} state_t;

  localparam logic [ADDR_W-1:0] HDR_OFS = ADDR_W'(512);

  state_t            state, state_nxt;
  logic              dl_q;
  logic [24:0]       cnt;
  logic [24:0]       cnt_inc;
  logic [24:0]       cnt_off;
  logic [ADDR_W-1:0] acc0;
  logic [ADDR_W-1:0] acc512;
  logic              start, accept, acked, finish;
  logic              hdr_nxt;
  logic              unused_bits;

  assign cnt_inc = cnt + 25'd1;
  assign cnt_off = cnt - 25'd512;
  // A copier header leaves the byte count exactly 512 past a 1 KiB multiple.
  assign hdr_nxt = (cnt[9:0] == 10'd512) && (cnt > 25'd512);
  assign unused_bits = ^{ioctl_index[7:5], cnt_off[24:ADDR_W]};

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    acked     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (ioctl_download && !dl_q) begin
          start     = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (ioctl_wr) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end else if (!ioctl_download) begin
          state_nxt = FINISH;
        end
      end
      BUSY: begin
        if (rom_wr_ack == rom_wr) begin
          acked     = 1'b1;
          state_nxt = ioctl_download ? STREAM : FINISH;
        end
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      cnt        <= '0;
      acc0       <= '0;
      acc512     <= '0;
      ioctl_wait <= 1'b0;
      rom_wr     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      cart_mask  <= '0;
      hdr        <= 1'b0;
      gg         <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      state <= state_nxt;
      dl_q  <= ioctl_download;
      if (start) begin
        cnt       <= '0;
        rom_waddr <= '0;
        acc0      <= '0;
        acc512    <= '0;
        loaded    <= 1'b0;
        gg        <= (ioctl_index[4:0] == GG_INDEX);
        // Adopt the SDRAM's ack level so the first toggle is a real request.
        rom_wr    <= rom_wr_ack;
      end
      if (accept) begin
        rom_wdata  <= ioctl_dout;
        rom_wr     <= ~rom_wr;
        ioctl_wait <= 1'b1;
        acc0       <= acc0 | cnt[ADDR_W-1:0];
        if (cnt >= 25'd512) begin
          acc512 <= acc512 | cnt_off[ADDR_W-1:0];
        end
      end
      if (acked) begin
        ioctl_wait <= 1'b0;
        cnt        <= cnt_inc;
        rom_waddr  <= cnt_inc[23:0];
      end
      if (finish) begin
        hdr       <= hdr_nxt;
        cart_mask <= hdr_nxt ? acc512 : acc0;
        loaded    <= (cnt != 25'd0);
      end
    end
  end

  assign rom_raddr = (cart_raddr & cart_mask) + (hdr ? HDR_OFS : '0);

endmodule

// File: tb/tb_cart_loader.sv
// Randomized download bench for cart_loader with an SDRAM ack model and a scoreboard.
module tb_cart_loader;
  localparam int AW = 22;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic          ioctl_wait;
  logic          rom_wr;
  logic          rom_wr_ack;
  logic [23:0]   rom_waddr;
  logic [7:0]    rom_wdata;
  logic [AW-1:0] cart_raddr = '0;
  logic [AW-1:0] rom_raddr;
  logic [AW-1:0] cart_mask;
  logic          hdr;
  logic          gg;
  logic          loaded;

  cart_loader #(.ADDR_W(AW), .GG_INDEX(5'd2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_wr(rom_wr), .rom_wr_ack(rom_wr_ack),
    .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .cart_raddr(cart_raddr),
    .rom_raddr(rom_raddr), .cart_mask(cart_mask), .hdr(hdr), .gg(gg), .loaded(loaded)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // SDRAM write side: a request toggle is acknowledged d_cur cycles after it appears.
  int   d_cur = 1;
  int   dly = 0;
  logic ack_r = 1'b0;
  logic wr_prev = 1'b0;
  logic tgt = 1'b0;
  logic ack_flip = 1'b0;
  assign rom_wr_ack = ack_r;

  always @(posedge clk_sys) begin
    wr_prev <= rom_wr;
    if (ack_flip) begin
      ack_r <= ~ack_r;
    end else if (dly > 0) begin
      if (dly == 1) ack_r <= tgt;
      dly <= dly - 1;
    end else if (!reset && rom_wr != wr_prev && rom_wr != ack_r) begin
      if (d_cur <= 1) ack_r <= rom_wr;
      else begin
        tgt <= rom_wr;
        dly <= d_cur - 1;
      end
    end
  end

  // Reference model of the cartridge map.
  logic [AW-1:0] exp_mask = '0;
  logic          exp_hdr = 1'b0;
  logic          exp_gg = 1'b0;
  logic          exp_loaded = 1'b0;
  logic          chk_res = 1'b0;
  logic          hold_chk = 1'b0;
  logic [7:0]    exp_q[$];
  int            n_writes = 0;
  int            base_w = 0;

  // OR of all integers 0..m-1 is the all-ones value covering the top bit of m-1.
  function automatic logic [AW-1:0] or_upto(input int m);
    int h;
    h = -1;
    if (m <= 0) return '0;
    for (int b = 0; b < 31; b++) if (((m - 1) >> b) & 1) h = b;
    return AW'((64'd1 << (h + 1)) - 64'd1);
  endfunction

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] a);
    int s;
    s = int'(a & exp_mask) + (exp_hdr ? 512 : 0);
    return AW'(s % (1 << AW));
  endfunction

  task automatic set_expect(input int n);
    exp_hdr    = ((n % 1024) == 512) && (n > 512);
    exp_mask   = or_upto(exp_hdr ? n - 512 : n);
    exp_loaded = (n != 0);
  endtask

  // Scoreboard: every write toggle, handshake stability, held results and the read map.
  logic       wr_seen = 1'b0;
  logic       pend = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [7:0]  cap_data = '0;

  always @(negedge clk_sys) begin
    if (reset) begin
      exp_q.delete();
      pend = 1'b0;
      wr_seen = 1'b0;
    end else begin
      if (rom_wr !== wr_seen) begin
        wr_seen = rom_wr;
        if (exp_q.size() > 0) begin
          cap_data = exp_q.pop_front();
          cap_addr = 24'(n_writes - base_w);
          check("waddr", 32'(rom_waddr), 32'(cap_addr));
          check("wdata", 32'(rom_wdata), 32'(cap_data));
          n_writes++;
          pend = 1'b1;
        end
      end else if (pend && rom_wr !== rom_wr_ack) begin
        check("waddr_hold", 32'(rom_waddr), 32'(cap_addr));
        check("wdata_hold", 32'(rom_wdata), 32'(cap_data));
      end
      if (rom_wr === rom_wr_ack) pend = 1'b0;
      if (hold_chk) begin
        check("mask_hold", 32'(cart_mask), 32'(exp_mask));
        check("hdr_hold", 32'(hdr), 32'(exp_hdr));
      end
      if (chk_res) begin
        check("mask", 32'(cart_mask), 32'(exp_mask));
        check("hdr", 32'(hdr), 32'(exp_hdr));
        check("gg", 32'(gg), 32'(exp_gg));
        check("loaded", 32'(loaded), 32'(exp_loaded));
        check("raddr", 32'(rom_raddr), 32'(map_addr(cart_raddr)));
        check("wr_idle", 32'(rom_wr), 32'(rom_wr_ack));
      end
    end
  end

  // mode 0: normal end; 1: drop download during the last write; 2: reset during the last write
  task automatic download(input int n, input logic [7:0] idx, input int d, input int mode);
    int hi;
    int guard;
    d_cur = d;
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    chk_res = 1'b0;
    base_w = n_writes;
    exp_gg = (idx[4:0] == 5'd2);
    @(negedge clk_sys);
    hold_chk = 1'b1;
    @(negedge clk_sys);
    check("loaded_clr", 32'(loaded), 32'(0));
    check("gg_start", 32'(gg), 32'(exp_gg));
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (ioctl_wait && guard < 300) begin
        @(negedge clk_sys);
        guard++;
      end
      if (guard >= 300) check("wait_timeout", 32'(guard), 32'(0));
      ioctl_dout = 8'($urandom);
      ioctl_wr = 1'b1;
      exp_q.push_back(ioctl_dout);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (i == n - 1 && mode == 2) begin
        #2;
        reset = 1'b1;
        ioctl_download = 1'b0;
        hold_chk = 1'b0;
        #1;
        check("rst_wait", 32'(ioctl_wait), 32'(0));
        check("rst_wr", 32'(rom_wr), 32'(0));
        check("rst_waddr", 32'(rom_waddr), 32'(0));
        check("rst_wdata", 32'(rom_wdata), 32'(0));
        check("rst_mask", 32'(cart_mask), 32'(0));
        check("rst_hdr", 32'(hdr), 32'(0));
        check("rst_gg", 32'(gg), 32'(0));
        check("rst_loaded", 32'(loaded), 32'(0));
        exp_mask = '0;
        exp_hdr = 1'b0;
        exp_gg = 1'b0;
        exp_loaded = 1'b0;
        repeat (d + 4) @(negedge clk_sys);
        reset = 1'b0;
        return;
      end
      if (i == n - 1 && mode == 1) begin
        ioctl_download = 1'b0;
        hold_chk = 1'b0;
      end
      hi = 0;
      while (ioctl_wait && hi < 300) begin
        hi++;
        @(negedge clk_sys);
      end
      check("wait_cycles", 32'(hi), 32'(d + 1));
    end
    if (mode == 0) begin
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      hold_chk = 1'b0;
    end
    repeat (3) @(negedge clk_sys);
    set_expect(n);
    check("n_writes", 32'(n_writes - base_w), 32'(n));
    check("waddr_end", 32'(rom_waddr), 32'(n));
    chk_res = 1'b1;
    repeat (12) begin
      @(posedge clk_sys);
      cart_raddr = AW'($urandom);
      @(negedge clk_sys);
    end
  endtask

  task automatic probe(input string name, input logic [AW-1:0] a, input logic [AW-1:0] exp);
    @(posedge clk_sys);
    cart_raddr = a;
    @(negedge clk_sys);
    check(name, 32'(rom_raddr), 32'(exp));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    #1;
    check("init_wait", 32'(ioctl_wait), 32'(0));
    check("init_wr", 32'(rom_wr), 32'(0));
    check("init_waddr", 32'(rom_waddr), 32'(0));
    check("init_wdata", 32'(rom_wdata), 32'(0));
    check("init_mask", 32'(cart_mask), 32'(0));
    check("init_flags", 32'({hdr, gg, loaded}), 32'(0));
    check("init_raddr", 32'(rom_raddr), 32'(0));

    download(2048, 8'd1, 3, 0);
    check("t1_mask", 32'(cart_mask), 32'h7FF);
    check("t1_hdr", 32'(hdr), 32'(0));
    check("t1_gg", 32'(gg), 32'(0));
    check("t1_loaded", 32'(loaded), 32'(1));
    check("t1_waddr", 32'(rom_waddr), 32'h800);
    probe("t1_raddr", AW'(32'h9234), AW'(32'h234));

    download(2560, 8'd2, 1, 0);
    check("t2_hdr", 32'(hdr), 32'(1));
    check("t2_mask", 32'(cart_mask), 32'h7FF);
    check("t2_gg", 32'(gg), 32'(1));
    probe("t2_raddr", AW'(32'h800), AW'(32'h200));

    download(3072, 8'd1, 1, 0);
    check("t3_mask", 32'(cart_mask), 32'hFFF);

    download(512, 8'd0, 1, 0);
    check("t4_hdr", 32'(hdr), 32'(0));
    check("t4_mask", 32'(cart_mask), 32'h1FF);

    download(6, 8'd1, 10, 1);
    check("t5_mask", 32'(cart_mask), 32'h7);

    download(0, 8'd1, 1, 0);
    check("t6_loaded", 32'(loaded), 32'(0));
    check("t6_mask", 32'(cart_mask), 32'(0));
    check("t6_hdr", 32'(hdr), 32'(0));

    download(101, 8'd1, 5, 2);
    @(negedge clk_sys);
    if (rom_wr_ack === rom_wr) begin
      ack_flip = 1'b1;
      @(negedge clk_sys);
      ack_flip = 1'b0;
    end
    check("t7_mismatch", 32'(rom_wr_ack != rom_wr), 32'(1));
    download(1024, 8'd1, 2, 0);
    check("t8_mask", 32'(cart_mask), 32'h3FF);

    repeat (6) begin
      n = ($urandom_range(0, 2) == 0) ? 1536 : $urandom_range(0, 900);
      download(n, 8'($urandom_range(0, 7)), $urandom_range(1, 3), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
